state_dump_unit: RTL

//   On CPU halt, streams the final architectural state out of the chip: every register-file entry, then every data-memory word.

---
 rtl/state_dump_unit_if.sv | 11 +
 rtl/state_dump_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/state_dump_unit_if.sv
// state_dump_unit_if: valid/ready word stream carrying the dumped CPU state
// Signals: out_valid (word present), out_ready (sink accepts), out_data (word),
// out_last (final word of the dump). master drives the stream, slave sinks it.
interface state_dump_unit_if #(parameter int DATA_W = 32);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/state_dump_unit.sv
// state_dump_unit: on CPU halt, streams every register then every memory word out
// Ports: clk, reset (async, active-high), halt (level), reg_addr/reg_data and
// mem_addr/mem_data (spare combinational read ports), s (stream master),
// busy (dump in progress), done (dump complete, sticky until reset).
// Optional macro DUMP_CHECKSUM_EN appends one XOR checksum word after memory.
module state_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 256,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  output logic [4:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  state_dump_unit_if.master s,
  output logic              busy,
  output logic              done
);
  localparam int IW = (ADDR_W > 5 ? ADDR_W : 5) + 1;
  typedef enum logic [2:0] {IDLE, REGS, MEM, SUM, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic load;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif
  // a new word may enter the output register when it is empty or being drained
  assign load     = !s.out_valid || s.out_ready;
  assign reg_addr = state == REGS ? idx[4:0] : '0;
  assign mem_addr = state == MEM ? idx[ADDR_W-1:0] : '0;
  assign busy     = state == REGS || state == MEM || state == SUM || (state == DONE && s.out_valid);
  assign done     = state == DONE && !s.out_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (halt) begin
          state <= REGS;
          idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
          csum  <= '0;
`endif
        end
        REGS: if (load) begin
          s.out_data  <= reg_data;
          s.out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          csum        <= csum ^ reg_data;
`endif
          state <= idx == IW'(NUM_REGS - 1) ? MEM : REGS;
          idx   <= idx == IW'(NUM_REGS - 1) ? '0 : idx + 1'b1;
        end
        MEM: if (load) begin
          s.out_data  <= mem_data;
          s.out_valid <= 1'b1;
          idx         <= idx == IW'(MEM_WORDS - 1) ? '0 : idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          csum        <= csum ^ mem_data;
          state       <= idx == IW'(MEM_WORDS - 1) ? SUM : MEM;
`else
          s.out_last  <= idx == IW'(MEM_WORDS - 1);
          state       <= idx == IW'(MEM_WORDS - 1) ? DONE : MEM;
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        SUM: if (load) begin
          s.out_data  <= csum;
          s.out_valid <= 1'b1;
          s.out_last  <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: if (s.out_valid && s.out_ready) begin
          s.out_valid <= 1'b0;
          s.out_last  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
